// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// sequencer state encoding and the iteration count.
package muldiv_pkg;

    // Number of radix-2 steps for a 32-bit operand.
    localparam int ITER = 32;

    // Op codes driven by the control unit (funct 0x18/0x19/0x1A/0x1B map to
    // MULT/MULTU/DIV/DIVU, funct 0x11/0x13 map to MTHI/MTLO; MFHI/MFLO use mf_req_i).
    typedef enum logic [2:0] {
        MULT  = 3'd0,
        MULTU = 3'd1,
        DIV   = 3'd2,
        DIVU  = 3'd3,
        MTHI  = 3'd4,
        MTLO  = 3'd5
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // True for the four iterative ops.
    function automatic logic is_muldiv(input logic [2:0] op);
        return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Accumulators and one radix-2 step for multiply (shift-add) and divide
// (restoring), plus the final sign correction. Sequencing lives in the top.
// Optional MULDIV_EARLY_TERM_EN: flags a multiply whose remaining multiplier
// bits are all zero so the sequencer can leave CALC early.
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            step,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    output logic            early_done,
    output logic [XLEN-1:0] res_hi,
    output logic [XLEN-1:0] res_lo
);
    localparam int W2 = 2 * XLEN;

    // Multiply: acc is the product, mcand the left-shifting multiplicand.
    // Divide: acc is {remainder, dividend/quotient}, mcand[XLEN-1:0] the divisor.
    logic [W2-1:0]   acc;
    logic [W2-1:0]   mcand;
    logic [XLEN-1:0] mplier;
    logic [XLEN-1:0] rs_raw;
    logic            is_div;
    logic            neg_q;
    logic            neg_r;
    logic            div_zero;

    logic            sgn_op;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN:0]   rem_shift;
    logic [XLEN:0]   diff;
    logic [W2-1:0]   prod;
    logic [XLEN-1:0] quo;
    logic [XLEN-1:0] rem;

    // Operand magnitudes and the restoring-divide trial subtraction.
    always_comb begin
        sgn_op    = (op == MULT) || (op == DIV);
        a_mag     = (sgn_op && rs_val[XLEN-1]) ? -rs_val : rs_val;
        b_mag     = (sgn_op && rt_val[XLEN-1]) ? -rt_val : rt_val;
        rem_shift = acc[W2-1:XLEN-1];
        diff      = rem_shift - {1'b0, mcand[XLEN-1:0]};
    end

    // Load on accept, then one step per cycle while the sequencer is in CALC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            rs_raw   <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
        end else if (load) begin
            is_div   <= (op == DIV) || (op == DIVU);
            neg_q    <= sgn_op && (rs_val[XLEN-1] ^ rt_val[XLEN-1]);
            neg_r    <= sgn_op && rs_val[XLEN-1];
            div_zero <= (rt_val == '0);
            rs_raw   <= rs_val;
            if ((op == DIV) || (op == DIVU)) begin
                acc    <= {{XLEN{1'b0}}, a_mag};
                mcand  <= {{XLEN{1'b0}}, b_mag};
                mplier <= '0;
            end else begin
                acc    <= '0;
                mcand  <= {{XLEN{1'b0}}, a_mag};
                mplier <= b_mag;
            end
        end else if (step) begin
            if (is_div) begin
                if (!diff[XLEN])
                    acc <= {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
                else
                    acc <= {rem_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
            end else begin
                acc    <= acc + (mplier[0] ? mcand : '0);
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
            end
        end
    end

    // Sign correction; a zero divisor forces LO=all-ones and HI=raw dividend.
    always_comb begin
        prod = neg_q ? -acc : acc;
        quo  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = neg_r ? -acc[W2-1:XLEN] : acc[W2-1:XLEN];
        if (is_div) begin
            res_hi = div_zero ? rs_raw : rem;
            res_lo = div_zero ? '1 : quo;
        end else begin
            res_hi = prod[W2-1:XLEN];
            res_lo = prod[XLEN-1:0];
        end
    end

`ifdef MULDIV_EARLY_TERM_EN
    // The step taken this cycle leaves no set multiplier bits behind.
    assign early_done = !is_div && (mplier[XLEN-1:1] == '0);
`else
    assign early_done = 1'b0;
`endif

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO, beside the EX ALU.
// Optional MULDIV_EARLY_TERM_EN: multiplies leave CALC once the remaining
// multiplier bits are zero.
// Handshake: an op is taken when start_i is high in IDLE or DONE and flush_i
// is low; while busy, a start_i or mf_req_i raises stall_o and the EX stage
// keeps re-presenting the same op until stall_o drops.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] rs_val_i,
    input  logic [XLEN-1:0] rt_val_i,
    input  logic            mf_req_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o,
    output state_t          state_dbg
);
    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               take;
    logic               load;
    logic               early_done;
    logic [XLEN-1:0]    res_hi;
    logic [XLEN-1:0]    res_lo;

    // Accept decode and the combinational stall toward the hazard unit.
    always_comb begin
        take    = ((state == IDLE) || (state == DONE)) && start_i && !flush_i;
        load    = take && is_muldiv(op_i);
        stall_o = busy_o && (start_i || mf_req_i);
    end

    assign state_dbg = state;

    muldiv_datapath #(
        .XLEN(XLEN)
    ) u_datapath (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .step       (state == CALC),
        .op         (op_i),
        .rs_val     (rs_val_i),
        .rt_val     (rt_val_i),
        .early_done (early_done),
        .res_hi     (res_hi),
        .res_lo     (res_lo)
    );

    // Sequencer FSM with registered busy/done and HI/LO ownership.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            hi_o   <= '0;
            lo_o   <= '0;
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                    if (take) begin
                        if (is_muldiv(op_i)) begin
                            state  <= CALC;
                            busy_o <= 1'b1;
                            cnt    <= '0;
                        end else if (op_i == MTHI) begin
                            hi_o <= rs_val_i;
                        end else if (op_i == MTLO) begin
                            lo_o <= rs_val_i;
                        end
                    end
                end
                CALC: begin
                    if (flush_i) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if ((cnt == CNT_W'(ITER - 1)) || early_done)
                            state <= FIX;
                    end
                end
                FIX: begin
                    busy_o <= 1'b0;
                    if (flush_i) begin
                        state <= IDLE;
                    end else begin
                        hi_o   <= res_hi;
                        lo_o   <= res_lo;
                        state  <= DONE;
                        done_o <= 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed corner cases plus
// randomized ops checked against an arithmetic reference model.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [2:0]  op_i;
    logic [31:0] rs_val_i;
    logic [31:0] rt_val_i;
    logic        mf_req_i;
    logic        flush_i;
    logic        stall_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    state_t      state_dbg;

    int          n_checks;
    int          n_err;
    logic [63:0] exp_q[$];
    logic [63:0] cur_hilo;

    muldiv_sequencer #(.XLEN(32), .CNT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (start_i),
        .op_i      (op_i),
        .rs_val_i  (rs_val_i),
        .rt_val_i  (rt_val_i),
        .mf_req_i  (mf_req_i),
        .flush_i   (flush_i),
        .stall_o   (stall_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .hi_o      (hi_o),
        .lo_o      (lo_o),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference result {HI, LO} from plain arithmetic.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] cur);
        logic signed [63:0] sa, sb, sq, sr;
        logic [63:0] ua, ub, uq, ur;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            3'd0: return sa * sb;
            3'd1: return ua * ub;
            3'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                sq = sa / sb;
                sr = sa % sb;
                return {sr[31:0], sq[31:0]};
            end
            3'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                uq = ua / ub;
                ur = ua % ub;
                return {ur[31:0], uq[31:0]};
            end
            3'd4: return {a, cur[31:0]};
            3'd5: return {cur[63:32], a};
            default: return cur;
        endcase
    endfunction

    // Cycles from accept edge to the done_o cycle.
    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] b);
`ifdef MULDIV_EARLY_TERM_EN
        logic [31:0] m;
        int n;
        if (op == 3'd0 || op == 3'd1) begin
            m = (op == 3'd0 && b[31]) ? -b : b;
            n = 1;
            for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
            return n + 2;
        end
`endif
        return 34;
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0: v = 32'd0;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'h8000_0000;
            3: v = 32'd1;
            4: v = $urandom_range(0, 255);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Drive one iterative op from a negedge; returns at the negedge of the done cycle.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit with_mf);
        int k;
        int lat;
        logic [63:0] exp;
        lat = exp_lat(op, b);
        exp_q.push_back(model(op, a, b, cur_hilo));
        start_i = 1'b1; op_i = op; rs_val_i = a; rt_val_i = b;
        #1 check("stall_on_accept", {63'd0, stall_o}, 64'd0);
        @(negedge clk);
        start_i = 1'b0; rs_val_i = $urandom; rt_val_i = $urandom;
        k = 1;
        check("busy_after_accept", {63'd0, busy_o}, 64'd1);
        if (with_mf) begin
            mf_req_i = 1'b1;
            #1;
        end
        while (!done_o && k < 60) begin
            if (with_mf) check("stall_while_busy", {63'd0, stall_o}, 64'd1);
            @(negedge clk);
            k++;
        end
        check("latency", 64'(k), 64'(lat));
        check("busy_in_done", {63'd0, busy_o}, 64'd0);
        if (with_mf) begin
            check("stall_in_done", {63'd0, stall_o}, 64'd0);
            mf_req_i = 1'b0;
        end
        exp = exp_q.pop_front();
        check("hi", {32'd0, hi_o}, {32'd0, exp[63:32]});
        check("lo", {32'd0, lo_o}, {32'd0, exp[31:0]});
        cur_hilo = exp;
    endtask

    // MTHI/MTLO from a negedge; returns one negedge later.
    task automatic run_mt(input logic [2:0] op, input logic [31:0] a);
        start_i = 1'b1; op_i = op; rs_val_i = a;
        #1 check("mt_stall", {63'd0, stall_o}, 64'd0);
        @(negedge clk);
        start_i = 1'b0;
        cur_hilo = model(op, a, 32'd0, cur_hilo);
        check("mt_hi", {32'd0, hi_o}, {32'd0, cur_hilo[63:32]});
        check("mt_lo", {32'd0, lo_o}, {32'd0, cur_hilo[31:0]});
    endtask

    initial begin
        bit seen_done;
        logic [2:0] op;
        n_checks = 0; n_err = 0; cur_hilo = '0;
        rst_n = 1'b0; start_i = 1'b0; op_i = 3'd0; rs_val_i = '0; rt_val_i = '0;
        mf_req_i = 1'b0; flush_i = 1'b0;
        #12;
        check("rst_busy", {63'd0, busy_o}, 64'd0);
        check("rst_done", {63'd0, done_o}, 64'd0);
        check("rst_stall", {63'd0, stall_o}, 64'd0);
        check("rst_hilo", {hi_o, lo_o}, 64'd0);
        check("rst_state", 64'(state_dbg), 64'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // directed corners
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        check("multu_max_hilo", {hi_o, lo_o}, 64'hFFFF_FFFE_0000_0001);
        run_op(3'd0, 32'hFFFF_FFFD, 32'd7, 0);
        check("mult_neg_hilo", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0);
        check("div_neg_hilo", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(3'd3, 32'd100, 32'd0, 0);
        check("divu_zero_hilo", {hi_o, lo_o}, 64'h0000_0064_FFFF_FFFF);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        check("div_ovf_hilo", {hi_o, lo_o}, 64'h0000_0000_8000_0000);
        run_op(3'd1, 32'd5, 32'd6, 1);
        check("multu_stall_lo", {32'd0, lo_o}, 64'd30);

        // flush mid-multiply leaves HI/LO alone
        @(negedge clk);
        run_mt(3'd5, 32'h1234);
        start_i = 1'b1; op_i = 3'd0; rs_val_i = 32'd3; rt_val_i = 32'h4000_0000;
        @(negedge clk);
        start_i = 1'b0;
        repeat (10) @(negedge clk);
        flush_i = 1'b1;
        #1 check("flush_busy_before", {63'd0, busy_o}, 64'd1);
        @(negedge clk);
        flush_i = 1'b0;
        check("flush_busy_after", {63'd0, busy_o}, 64'd0);
        check("flush_state", 64'(state_dbg), 64'(IDLE));
        seen_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done_o) seen_done = 1'b1;
        end
        check("flush_no_done", {63'd0, seen_done}, 64'd0);
        check("flush_lo", {32'd0, lo_o}, 64'h1234);
        check("flush_hilo", {hi_o, lo_o}, cur_hilo);

        // flush in IDLE blocks a simultaneous start
        start_i = 1'b1; op_i = 3'd4; rs_val_i = 32'hDEAD_BEEF; flush_i = 1'b1;
        @(negedge clk);
        op_i = 3'd0;
        @(negedge clk);
        start_i = 1'b0; flush_i = 1'b0;
        check("idle_flush_busy", {63'd0, busy_o}, 64'd0);
        check("idle_flush_hilo", {hi_o, lo_o}, cur_hilo);

        // randomized mix, ops back to back (next start lands in DONE)
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 5));
            if (op >= 3'd4) run_mt(op, pick());
            else run_op(op, pick(), pick(), ($urandom_range(0, 3) == 0));
        end

        // async reset in the middle of CALC
        @(negedge clk);
        run_mt(3'd4, 32'hA5A5_0001);
        start_i = 1'b1; op_i = 3'd1; rs_val_i = 32'd77; rt_val_i = 32'hF000_0003;
        @(negedge clk);
        start_i = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("areset_busy", {63'd0, busy_o}, 64'd0);
        check("areset_hilo", {hi_o, lo_o}, 64'd0);
        check("areset_state", 64'(state_dbg), 64'(IDLE));
        cur_hilo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(3'd3, 32'd1000, 32'd7, 0);
        check("post_reset_divu", {hi_o, lo_o}, {32'd6, 32'd142});

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        n_err++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multiply/divide unit with its FSM, sitting beside the EX-stage ALU of the 5-stage MIPS pipeline.
- Executes MULT/MULTU/DIV/DIVU over multiple cycles and owns the HI/LO registers, including MTHI/MTLO writes.
- Drives a stall to the hazard logic while an MFHI/MFLO or a new mul/div op must wait for a running op.

Parameters:
- XLEN, 32, operand and HI/LO width; fixed at 32 for MIPS-I, parameterised for bench reuse.
- CNT_W, 5, iteration counter width; log2(XLEN).

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  EX stage holds a valid mul/div/mthi/mtlo op this cycle.
- op_i  in  3  op code from the shared package: MULT, MULTU, DIV, DIVU, MTHI, MTLO.
- rs_val_i  in  XLEN  forwarded rs operand; dividend, multiplicand, or MTHI/MTLO data.
- rt_val_i  in  XLEN  forwarded rt operand; divisor or multiplier.
- mf_req_i  in  1  EX stage holds MFHI or MFLO.
- flush_i  in  1  abort the running op; this is a branch/exception flush of the owning instruction.
- stall_o  out  1  hold IF/ID/EX and bubble MEM.
- busy_o  out  1  an iterative op is in flight.
- done_o  out  1  single-cycle pulse; HI/LO now hold a new result.
- hi_o  out  XLEN  HI register.
- lo_o  out  XLEN  LO register.

Behaviour:
- Reset: state=IDLE; HI, LO, counter and accumulators = 0; busy_o=0, done_o=0, stall_o=0.
- States are IDLE, CALC, FIX, DONE. busy_o = (state==CALC) | (state==FIX).
- IDLE, start_i with MULT..DIVU:
  - At the edge, latch operand magnitudes (abs for signed ops) and the result signs, clear the counter, go to CALC.
  - The op is accepted without stall.
- IDLE, start_i with MTHI/MTLO: write rs_val_i into HI or LO at the edge. Stay in IDLE with no stall.
- CALC runs one radix-2 step per cycle for 32 cycles (counter 0..31), then goes to FIX.
  - Multiply: shift-add into a 2*XLEN product.
  - Divide: restoring divide with a 33-bit partial remainder.
- FIX applies sign correction, then writes HI/LO at the end of the cycle and goes to DONE.
  - Signed multiply negates the 64-bit product.
  - Signed divide: quotient sign = sign(rs)^sign(rt); remainder sign = sign(rs).
- DONE: done_o=1 for one cycle, then IDLE. A start_i in DONE is handled exactly as in IDLE.
- Latency: accept at edge N, busy cycles N+1..N+33, done_o in cycle N+34 with hi_o/lo_o valid.
- stall_o is combinational: busy_o & (start_i | mf_req_i). It is never asserted in IDLE or DONE.
  - While stalled, start_i is not accepted; the op is re-presented each cycle.
- Divide by zero: LO = all-ones, HI = dividend (rs_val, unmodified). Full latency still applies.
- Signed overflow 0x80000000 / -1: LO = 0x80000000, HI = 0.
- flush_i while busy: go to IDLE at the next edge. HI/LO are unchanged and no done_o is produced.
- flush_i in IDLE/DONE: no effect on HI/LO. A simultaneous start_i is ignored.
- Async reset mid-op: immediate return to reset values, including HI/LO.

Optional Feature:
- Macro MULDIV_EARLY_TERM_EN.
- When defined, multiply CALC goes to FIX as soon as the remaining multiplier magnitude bits are zero, after at least 1 iteration. Latency varies from 3 to 34 cycles; done_o still follows FIX by one cycle.
- When undefined, latency is fixed as above. Divide is never early-terminated.

Decomposition:
- Shared package muldiv_pkg holds:
  - op_i encodings: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5.
  - FSM state encodings.
  - The ITER=32 constant.
- The control unit maps funct 0x18/0x19/0x1A/0x1B/0x10/0x12/0x11/0x13 onto these encodings.
- One sub-module, muldiv_datapath, holds the accumulators, one step of shift-add/restoring-subtract, and the sign fix. The FSM, counter, stall and HI/LO stay in the top.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> done_o exactly 34 cycles after accept; HI=0xFFFFFFFE, LO=0x00000001.
- MULT rs=0xFFFFFFFD (-3), rt=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100/0 -> LO=0xFFFFFFFF, HI=0x00000064; DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- MULTU 5x6 accepted, mf_req_i held from the next cycle -> stall_o=1 for cycles N+1..N+33, 0 in the done_o cycle; LO=30.
- MTLO 0x1234 in IDLE, then MULT started and flush_i at iteration 10 -> IDLE next edge, no done_o, LO still 0x1234.
- rst_n low mid-CALC -> busy_o, HI, LO all 0 without a clock edge; a following start_i works normally.
